// File: rtl/leer_fecha.sv
// leer_fecha: reads day, month, year and weekday from the RTC (addresses 24h..27h)
// through the bus controller and publishes them together as one coherent date.
// Optional build macro LEER_FECHA_BCD_CHECK_EN rejects captured bytes whose
// nibbles are not both in 0..9.
//
// state        | meaning
// ESPERA       | idle, waiting for inicio
// PEDIR        | presenting address, waiting for the bus (siga=0) to strobe
// ESPERAR_DATO | strobe issued, waiting for dato_ok or timeout
// FIN          | all four bytes captured, publish the date
module leer_fecha (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       siga,
    input  logic       dato_ok,
    input  logic [7:0] dato_rd,
    output logic [7:0] direc,
    output logic       flag_rtc,
    output logic       lea_escriba,
    output logic       leyendo,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] year,
    output logic [7:0] dia_semana,
    output logic       fecha_lista,
    output logic       error_rtc
);

    typedef enum logic [1:0] {
        ESPERA       = 2'd0,
        PEDIR        = 2'd1,
        ESPERAR_DATO = 2'd2,
        FIN          = 2'd3
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0][7:0] sombra_q, sombra_d;
    logic [3:0][7:0] fecha_q, fecha_d;
    logic            flag_q, flag_d;
    logic            lista_q, lista_d;
    logic            error_q, error_d;
    logic            dato_invalido;

`ifdef LEER_FECHA_BCD_CHECK_EN
    assign dato_invalido = (dato_rd[7:4] > 4'd9) || (dato_rd[3:0] > 4'd9);
`else
    assign dato_invalido = 1'b0;
`endif

    // State and datapath registers; reset abandons any transaction silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= ESPERA;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            sombra_q <= '0;
            fecha_q  <= '0;
            flag_q   <= 1'b0;
            lista_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sombra_q <= sombra_d;
            fecha_q  <= fecha_d;
            flag_q   <= flag_d;
            lista_q  <= lista_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic; dato_ok wins over the timeout in the same cycle.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sombra_d = sombra_q;
        fecha_d  = fecha_q;
        flag_d   = 1'b0;
        lista_d  = 1'b0;
        error_d  = 1'b0;
        case (estado_q)
            ESPERA: begin
                if (inicio) begin
                    idx_d    = 2'd0;
                    estado_d = PEDIR;
                end
            end
            PEDIR: begin
                if (!siga) begin
                    flag_d   = 1'b1;
                    cnt_d    = 8'd0;
                    estado_d = ESPERAR_DATO;
                end
            end
            ESPERAR_DATO: begin
                if (dato_ok) begin
                    if (dato_invalido) begin
                        error_d  = 1'b1;
                        sombra_d = '0;
                        estado_d = ESPERA;
                    end else begin
                        sombra_d[idx_q] = dato_rd;
                        if (idx_q == 2'd3) begin
                            estado_d = FIN;
                        end else begin
                            idx_d    = idx_q + 2'd1;
                            estado_d = PEDIR;
                        end
                    end
                end else if (cnt_q == 8'd255) begin
                    error_d  = 1'b1;
                    sombra_d = '0;
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIN: begin
                fecha_d  = sombra_q;
                lista_d  = 1'b1;
                estado_d = ESPERA;
            end
            default: estado_d = ESPERA;
        endcase
    end

    // Address is held from PEDIR entry through ESPERAR_DATO since idx only moves on exit.
    assign direc       = (estado_q == PEDIR || estado_q == ESPERAR_DATO) ? (8'h24 + {6'd0, idx_q}) : 8'h00;
    assign lea_escriba = !(estado_q == PEDIR || estado_q == ESPERAR_DATO);
    assign leyendo     = (estado_q != ESPERA);
    assign flag_rtc    = flag_q;
    assign fecha_lista = lista_q;
    assign error_rtc   = error_q;
    assign dia         = fecha_q[0];
    assign mes         = fecha_q[1];
    assign year        = fecha_q[2];
    assign dia_semana  = fecha_q[3];

endmodule

// File: tb/tb_leer_fecha.sv
// Bench for leer_fecha: stimulus queues expected strobes/dates/errors, a monitor
// pops and compares them whenever the DUT presents flag_rtc, fecha_lista or error_rtc.
module tb_leer_fecha;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       siga = 1'b0;
    logic       dato_ok = 1'b0;
    logic [7:0] dato_rd = 8'h00;
    logic [7:0] direc, dia, mes, year, dia_semana;
    logic       flag_rtc, lea_escriba, leyendo, fecha_lista, error_rtc;

    localparam logic [1:0] EV_STROBE = 2'd0;
    localparam logic [1:0] EV_LISTA  = 2'd1;
    localparam logic [1:0] EV_ERROR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  direc;
        logic [31:0] fecha;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;

    leer_fecha dut (
        .clk(clk), .reset(reset), .inicio(inicio), .siga(siga),
        .dato_ok(dato_ok), .dato_rd(dato_rd), .direc(direc),
        .flag_rtc(flag_rtc), .lea_escriba(lea_escriba), .leyendo(leyendo),
        .dia(dia), .mes(mes), .year(year), .dia_semana(dia_semana),
        .fecha_lista(fecha_lista), .error_rtc(error_rtc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic check_event(input logic [1:0] k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d, required no event", k);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            errors++;
            $display("FAIL event_kind: got %0d, required %0d", k, e.kind);
        end else if (k == EV_STROBE && direc !== e.direc) begin
            errors++;
            $display("FAIL strobe_direc: got %h, required %h", direc, e.direc);
        end else if (k != EV_STROBE && {dia, mes, year, dia_semana} !== e.fecha) begin
            errors++;
            $display("FAIL event_fecha: got %h, required %h", {dia, mes, year, dia_semana}, e.fecha);
        end
    endtask

    // Monitor: compare every DUT output event against the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (flag_rtc)    check_event(EV_STROBE);
            if (fecha_lista) check_event(EV_LISTA);
            if (error_rtc)   check_event(EV_ERROR);
        end
    end

    task automatic push_ev(input logic [1:0] k, input logic [7:0] d, input logic [31:0] f);
        ev_t e;
        e.kind  = k;
        e.direc = d;
        e.fecha = f;
        exp_q.push_back(e);
    endtask

    task automatic push_strobes(input int n);
        for (int i = 0; i < n; i++) push_ev(EV_STROBE, 8'h24 + 8'(i), 32'h0);
    endtask

    task automatic wait_strobe();
        int n = 0;
        @(negedge clk);
        while (!flag_rtc && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_wait", {31'd0, flag_rtc}, 32'd1);
    endtask

    task automatic respond(input logic [7:0] b, input int delay);
        repeat (delay) @(negedge clk);
        dato_rd = b;
        dato_ok = 1'b1;
        @(negedge clk);
        dato_ok = 1'b0;
        dato_rd = 8'h00;
    endtask

    // Waits for fecha_lista (sel=0) or error_rtc (sel=1); n = negedges waited.
    task automatic wait_out(input int sel, input int limit, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = (sel == 0) ? fecha_lista : error_rtc;
        end
        chk(sel == 0 ? "lista_wait" : "error_wait", {31'd0, seen}, 32'd1);
    endtask

    task automatic start_read();
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic full_read(input logic [31:0] bytes);
        int n;
        for (int i = 0; i < 4; i++) begin
            wait_strobe();
            respond(bytes[31-8*i -: 8], 1);
        end
        wait_out(0, 20, n);
    endtask

    initial begin
        int n;
        int t0;
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_direc", {24'd0, direc}, 32'h0);
        chk("rst_flag", {31'd0, flag_rtc}, 32'd0);
        chk("rst_lea_escriba", {31'd0, lea_escriba}, 32'd1);
        chk("rst_leyendo", {31'd0, leyendo}, 32'd0);
        chk("rst_fecha", {dia, mes, year, dia_semana}, 32'h0);
        chk("rst_pulses", {30'd0, fecha_lista, error_rtc}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_inicio", {31'd0, leyendo}, 32'd0);

        // nominal read
        push_strobes(4);
        push_ev(EV_LISTA, 8'h0, 32'h15041703);
        t0 = cyc;
        start_read();
        chk("pedir_lea_escriba", {31'd0, lea_escriba}, 32'd0);
        chk("pedir_leyendo", {31'd0, leyendo}, 32'd1);
        full_read(32'h15041703);
        chk("latencia_min", {31'd0, (cyc - t0) >= 13}, 32'd1);
        chk("nominal_fecha", {dia, mes, year, dia_semana}, 32'h15041703);
        @(negedge clk);
        chk("nominal_idle", {31'd0, leyendo}, 32'd0);

        // bus busy: ten cycles in PEDIR without strobe, address held
        siga = 1'b1;
        push_strobes(4);
        push_ev(EV_LISTA, 8'h0, 32'h21129907);
        start_read();
        for (int i = 0; i < 10; i++) begin
            chk("busy_no_flag", {31'd0, flag_rtc}, 32'd0);
            chk("busy_direc", {24'd0, direc}, 32'h24);
            @(negedge clk);
        end
        siga = 1'b0;
        full_read(32'h21129907);

        // timeout after the month strobe
        push_strobes(2);
        push_ev(EV_ERROR, 8'h0, 32'h21129907);
        start_read();
        wait_strobe();
        respond(8'h31, 1);
        wait_strobe();
        wait_out(1, 400, n);
        chk("timeout_ciclos", n, 32'd256);
        chk("timeout_fecha", {dia, mes, year, dia_semana}, 32'h21129907);
        @(negedge clk);
        chk("timeout_espera", {31'd0, leyendo}, 32'd0);

        // dato_ok on the cycle the counter reaches 255 wins
        push_strobes(4);
        push_ev(EV_LISTA, 8'h0, 32'h30062501);
        start_read();
        wait_strobe();
        respond(8'h30, 1);
        wait_strobe();
        respond(8'h06, 255);
        wait_strobe();
        chk("prioridad_direc", {24'd0, direc}, 32'h26);
        respond(8'h25, 1);
        wait_strobe();
        respond(8'h01, 1);
        wait_out(0, 20, n);
        chk("prioridad_fecha", {dia, mes, year, dia_semana}, 32'h30062501);

        // reset after the year strobe
        push_strobes(3);
        start_read();
        wait_strobe();
        respond(8'h11, 1);
        wait_strobe();
        respond(8'h11, 1);
        wait_strobe();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rr_direc", {24'd0, direc}, 32'h0);
        chk("rr_lea_escriba", {31'd0, lea_escriba}, 32'd1);
        chk("rr_leyendo", {31'd0, leyendo}, 32'd0);
        chk("rr_fecha", {dia, mes, year, dia_semana}, 32'h0);
        chk("rr_pulses", {29'd0, flag_rtc, fecha_lista, error_rtc}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_idle", {29'd0, leyendo, fecha_lista, error_rtc}, 32'd0);
        push_strobes(4);
        push_ev(EV_LISTA, 8'h0, 32'h28022404);
        start_read();
        full_read(32'h28022404);
        chk("rr_fecha_nueva", {dia, mes, year, dia_semana}, 32'h28022404);

        // non-BCD month byte
        start_read();
`ifdef LEER_FECHA_BCD_CHECK_EN
        push_strobes(2);
        push_ev(EV_ERROR, 8'h0, 32'h28022404);
        wait_strobe();
        respond(8'h09, 1);
        wait_strobe();
        respond(8'h1A, 1);
        wait_out(1, 20, n);
        chk("bcd_fecha", {dia, mes, year, dia_semana}, 32'h28022404);
`else
        push_strobes(4);
        push_ev(EV_LISTA, 8'h0, 32'h091A2405);
        full_read(32'h091A2405);
        chk("bcd_mes", {24'd0, mes}, 32'h1A);
`endif

        repeat (5) @(negedge clk);
        chk("cola_vacia", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leer_fecha.md
LEER_FECHA -- requirements
Module: leer_fecha

Interface
REQ-001 SHALL have the following ports; reset is asynchronous and active-high; clock is clk:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- inicio  in  1  level request to read the date; sampled in ESPERA only
- siga  in  1  bus controller ready, active-low; 0 = can accept a transaction
- dato_ok  in  1  one-cycle pulse; dato_rd is valid
- dato_rd  in  8  byte read back from the RTC
- direc  out  8  RTC register address of the current transaction
- flag_rtc  out  1  one-cycle transaction request strobe
- lea_escriba  out  1  transaction direction; 0 = read
- leyendo  out  1  high while the block is not in ESPERA
- dia, mes, year, dia_semana  out  8 each  last complete date read, BCD
- fecha_lista  out  1  one-cycle pulse; all four date outputs just updated
- error_rtc  out  1  one-cycle pulse; read aborted

Function
REQ-002 SHALL implement states ESPERA, PEDIR, ESPERAR_DATO and FIN, with a 2-bit index idx (0..3).
REQ-003 In ESPERA with inicio=1, SHALL set idx=0 and enter PEDIR on the next edge; with inicio=0, SHALL stay in ESPERA.
REQ-004 In PEDIR, direc SHALL be 8'h24+idx: 24 day, 25 month, 26 year, 27 weekday.
REQ-005 In PEDIR, lea_escriba SHALL be 0.
REQ-006 In PEDIR with siga=0, SHALL register flag_rtc=1 for exactly one cycle, clear the timeout counter and enter ESPERAR_DATO; with siga=1, SHALL stay in PEDIR with no strobe.
REQ-007 direc SHALL stay stable from PEDIR entry until ESPERAR_DATO exits.
REQ-008 In ESPERAR_DATO with dato_ok=1, SHALL store dato_rd into shadow register idx.
REQ-009 After that capture: if idx<3, SHALL increment idx and enter PEDIR; if idx=3, SHALL enter FIN.
REQ-010 In ESPERAR_DATO, SHALL increment an 8-bit timeout counter each cycle dato_ok=0.
REQ-011 When the timeout counter reaches 255, SHALL pulse error_rtc for one cycle, discard the shadow registers and enter ESPERA; the date outputs SHALL stay unchanged.
REQ-012 If dato_ok=1 in the same cycle the counter reaches 255, SHALL treat dato_ok as taking priority: no error, data captured.
REQ-013 In FIN, SHALL copy all four shadow registers to dia/mes/year/dia_semana in the same edge.
REQ-014 In FIN, SHALL pulse fecha_lista for one cycle and enter ESPERA; the date outputs SHALL never show a mix of two reads.
REQ-015 SHALL ignore inicio outside ESPERA, and SHALL ignore dato_ok outside ESPERAR_DATO.
REQ-016 If inicio is still 1 on the ESPERA cycle after FIN, SHALL start a new read, giving continuous polling.
REQ-017 leyendo SHALL be combinational from state: 1 in PEDIR, ESPERAR_DATO and FIN.
REQ-018 SHALL take at least 2+3+2*4 cycles from inicio to fecha_lista, assuming siga=0 and dato_ok arrives the cycle after each strobe.

Reset
REQ-019 On reset, SHALL set state=ESPERA, idx=0, timeout counter=0 and the shadow registers to 0.
REQ-020 On reset, all outputs SHALL be 0, except lea_escriba=1 (idle, not reading).
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction, with no fecha_lista and no error_rtc pulse.

Configuration
REQ-022 Macro LEER_FECHA_BCD_CHECK_EN SHALL control BCD validation of each captured byte.
REQ-023 With LEER_FECHA_BCD_CHECK_EN defined:
- each captured byte SHALL be checked; it is valid only if both nibbles are <=9
- an invalid byte SHALL pulse error_rtc, discard the shadow registers and return to ESPERA, with the date outputs unchanged
REQ-024 Without LEER_FECHA_BCD_CHECK_EN, bytes SHALL be accepted unchecked and no BCD logic SHALL be synthesized.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- Nominal read: inicio=1, siga=0, dato_ok one cycle after each strobe with 8'h15,8'h04,8'h17,8'h03 -> strobes at direc 24,25,26,27; then dia=15, mes=04, year=17, dia_semana=03, one fecha_lista pulse.
- Bus busy: siga=1 for 10 cycles in PEDIR -> no flag_rtc, direc=24 held; siga=0 -> single strobe.
- Timeout: no dato_ok after the month strobe -> error_rtc at counter 255; outputs keep the previous date; state ESPERA.
- Priority: dato_ok on the cycle the counter hits 255 -> no error, read continues to direc 26.
- Reset mid-read: reset after the year strobe -> all outputs 0, lea_escriba=1, no pulses; the next inicio restarts at direc 24.
- BCD check (EN defined): month byte 8'h1A -> error_rtc, outputs unchanged; EN undefined -> mes=1A accepted.
